// File: rtl/tanh_pwl_interp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tanh_pwl_interp_pkg
//  Purpose  : Shared NN activation constants, Q-format types and the
//             piecewise-linear interpolation core (reusable by sigmoid).
//  Revision : 1.0  initial release
// ============================================================================
package tanh_pwl_interp_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 4;
  localparam int FRAC_W     = 4;
  localparam int ROUND_HALF = 1 << (FRAC_W - 1);

  // Intermediate widths of the interpolation datapath
  localparam int DELTA_W = DATA_W + 1;
  localparam int PROD_W  = DELTA_W + FRAC_W + 1;
  localparam int SUM_W   = DATA_W + 2;

  typedef logic signed [DATA_W-1:0] act_t;
  typedef logic        [ADDR_W-1:0] addr_t;
  typedef logic        [FRAC_W-1:0] frac_t;

  typedef struct packed {
    logic sat;
    act_t y;
  } pwl_res_t;

  // y = base + round((next - base) * frac / 2^FRAC_W), clamped to act_t range.
  // The fraction is zero-extended so the multiply stays signed throughout.
  function automatic pwl_res_t pwl_core(act_t base, act_t next_data, frac_t frac);
    logic signed [DELTA_W-1:0] delta;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  rnd;
    logic signed [SUM_W-1:0]   corr;
    logic signed [SUM_W-1:0]   sum;
    pwl_res_t                  res;
    delta = {next_data[DATA_W-1], next_data} - {base[DATA_W-1], base};
    prod  = $signed({{(PROD_W-DELTA_W){delta[DELTA_W-1]}}, delta})
          * $signed({{(PROD_W-FRAC_W){1'b0}}, frac});
    rnd   = prod + PROD_W'(ROUND_HALF);
    // Arithmetic shift gives floor division, so +half rounds half up
    corr  = SUM_W'(rnd >>> FRAC_W);
    sum   = {{(SUM_W-DATA_W){base[DATA_W-1]}}, base} + corr;
    // Overflow when the bits above the act_t sign bit disagree with it
    if (sum[SUM_W-1:DATA_W-1] != {(SUM_W-DATA_W+1){sum[SUM_W-1]}}) begin
      res.sat = 1'b1;
      res.y   = sum[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      res.sat = 1'b0;
      res.y   = sum[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tanh_pwl_interp_if.sv
`default_nettype none
// ============================================================================
//  Module   : tanh_pwl_interp_if
//  Purpose  : Input stream, output stream and LUT read port of the tanh
//             interpolator. The interpolator is the slave side.
//  Revision : 1.0  initial release
// ============================================================================
interface tanh_pwl_interp_if;
  import tanh_pwl_interp_pkg::*;

  logic  in_valid;
  logic  in_ready;
  act_t  in_x;
  addr_t lut_address;
  act_t  lut_base;
  act_t  lut_next;
  logic  out_valid;
  logic  out_ready;
  act_t  out_y;
  logic  out_sat;

  modport slave (
    input  in_valid, in_x, lut_base, lut_next, out_ready,
    output in_ready, lut_address, out_valid, out_y, out_sat
  );

  modport master (
    output in_valid, in_x, lut_base, lut_next, out_ready,
    input  in_ready, lut_address, out_valid, out_y, out_sat
  );

endinterface
`default_nettype wire

// File: rtl/tanh_pwl_interp_lut.sv
`default_nettype none
// ============================================================================
//  Module   : tanh_pwl_interp_lut
//  Purpose  : Shipped 16-entry tanh segment table with combinational read.
//             next_data clamps at the top segment and wraps across zero.
//  Revision : 1.0  initial release
// ============================================================================
module tanh_pwl_interp_lut
  import tanh_pwl_interp_pkg::*;
(
  input  addr_t address,
  output act_t  base,
  output act_t  next_data
);

  addr_t w_next_addr;

  function automatic act_t entry(addr_t a);
    act_t v;
    case (a)
      4'd0:    v = 8'h00;  //    0
      4'd1:    v = 8'h10;  //   16
      4'd2:    v = 8'h20;  //   32
      4'd3:    v = 8'h30;  //   48
      4'd4:    v = 8'h40;  //   64
      4'd5:    v = 8'h50;  //   80
      4'd6:    v = 8'h60;  //   96
      4'd7:    v = 8'h70;  //  112
      4'd8:    v = 8'h80;  // -128
      4'd9:    v = 8'h90;  // -112
      4'd10:   v = 8'hA0;  //  -96
      4'd11:   v = 8'hB0;  //  -80
      4'd12:   v = 8'hC0;  //  -64
      4'd13:   v = 8'hD0;  //  -48
      4'd14:   v = 8'hE0;  //  -32
      default: v = 8'hF0;  //  -16
    endcase
    return v;
  endfunction

  // Address 15 + 1 wraps to 0, making the -16..0 segment continuous
  assign w_next_addr = address + addr_t'(1);

  // Top positive segment is flat: next repeats base instead of wrapping negative
  always_comb begin
    base      = entry(address);
    next_data = (address == addr_t'(7)) ? entry(address) : entry(w_next_addr);
  end

endmodule
`default_nettype wire

// File: rtl/tanh_pwl_interp.sv
`default_nettype none
// ============================================================================
//  Module   : tanh_pwl_interp
//  Purpose  : Two-stage valid/ready tanh interpolator. S1 splits x into LUT
//             address and fraction; S2 registers base + (next-base)*frac/16.
//  Revision : 1.0  initial release
// ============================================================================
module tanh_pwl_interp
  import tanh_pwl_interp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  tanh_pwl_interp_if.slave bus
);

  logic     r_s1_valid;
  addr_t    r_s1_addr;
  frac_t    r_s1_frac;
  logic     r_out_valid;
  act_t     r_out_y;
  logic     r_out_sat;

  logic     w_s2_adv;
  logic     w_in_ready;
  pwl_res_t w_res;

  // Output register may advance when empty or being drained this cycle
  assign w_s2_adv   = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;

  // LUT is read combinationally from the S1 address, even while idle
  assign w_res           = pwl_core(bus.lut_base, bus.lut_next, r_s1_frac);
  assign bus.in_ready    = w_in_ready;
  assign bus.lut_address = r_s1_addr;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_y       = r_out_y;
  assign bus.out_sat     = r_out_sat;

  // S1: capture the segment address and fraction of an accepted x
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_frac  <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_addr <= bus.in_x[DATA_W-1 -: ADDR_W];
        r_s1_frac <= bus.in_x[FRAC_W-1:0];
      end
    end
  end

  // S2: register the interpolated result; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_y   <= w_res.y;
        r_out_sat <= w_res.sat;
      end
    end
  end

endmodule
`default_nettype wire
